// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg7_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } state_e;

   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  dp;
   } disp_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Active-low {a,b,c,d,e,f,g,dp} patterns with dp off; entry 0 is the least significant.
   localparam logic [15:0][7:0] SEG_HEX = {
      8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
      8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
   };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit + decimal point to active-low segment pattern.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   input  logic       dp,
   output logic [7:0] seg_c
);

   logic [7:0] pattern;

   always_comb begin
      pattern = SEG_HEX[hex];
      seg_c   = {pattern[7:1], ~dp};
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with blanking gaps, frame-aligned
// updates through a valid/ready port and optional leading-zero blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned ON_CYCLES    = 49_950,
   parameter int unsigned BLANK_CYCLES = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [15:0] upd_value,
   input  logic [3:0]  upd_dp,
   input  logic        lz_blank,
   output logic [7:0]  seg,
   output logic [3:0]  digit,
   output logic        frame_tick
);

   localparam int unsigned MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
   localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    index_q, index_d;
   disp_t         active_q, active_d;
   disp_t         shadow_q, shadow_d;
   logic          pending_q, pending_d;
   logic          upd_ready_q, upd_ready_d;
   logic [7:0]    seg_q, seg_d;
   logic [3:0]    digit_q, digit_d;
   logic          frame_tick_q, frame_tick_d;

   logic          phase_last;
   logic          frame_end;
   logic          accept;
   logic [3:0][3:0] nib;
   logic [3:0]    nz;
   logic [3:0]    lz_mask;
   logic [3:0]    cur_hex;
   logic          cur_dp;
   logic [7:0]    dec_seg_c;

   seg7_hex_decode u_dec (
      .hex   (cur_hex),
      .dp    (cur_dp),
      .seg_c (dec_seg_c)
   );

   // Digit selection and leading-zero mask from the committed value
   always_comb begin
      nib     = active_q.value;
      nz      = '0;
      for (int k = 0; k < 4; k++) begin
         nz[k] = |nib[k];
      end
      lz_mask    = 4'b0000;
      lz_mask[3] = ~nz[3];
      lz_mask[2] = ~(|nz[3:2]);
      lz_mask[1] = ~(|nz[3:1]);
      cur_hex    = nib[index_q];
      cur_dp     = active_q.dp[index_q];
   end

   // Slot sequencing, update handshake and registered display outputs
   always_comb begin
      state_d      = state_q;
      timer_d      = TW'(timer_q + 1'b1);
      index_d      = index_q;
      active_d     = active_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      seg_d        = SEG_BLANK;
      digit_d      = 4'b0000;

      phase_last = (state_q == ON) ? (timer_q == ON_LAST) : (timer_q == BLANK_LAST);
      frame_end  = (state_q == ON) && phase_last && (index_q == 2'd3);
      accept     = upd_valid & upd_ready_q;

      if (phase_last) begin
         timer_d = '0;
         if (state_q == ON) begin
            state_d = BLANK;
            index_d = 2'(index_q + 2'd1);
         end else begin
            state_d = ON;
         end
      end

      if (accept) begin
         shadow_d  = '{value: upd_value, dp: upd_dp};
         pending_d = 1'b1;
      end else if (frame_end) begin
         pending_d = 1'b0;
      end

      if (frame_end && pending_q) begin
         active_d = shadow_q;
      end

      // Ready stays low through the commit edge and rises on the following one
      upd_ready_d  = ~(pending_q | accept);
      frame_tick_d = frame_end;

      if (state_q == ON) begin
         digit_d = 4'b0001 << index_q;
         seg_d   = (lz_blank && lz_mask[index_q]) ? SEG_BLANK : dec_seg_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BLANK;
         timer_q      <= '0;
         index_q      <= 2'd0;
         active_q     <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         upd_ready_q  <= 1'b1;
         seg_q        <= SEG_BLANK;
         digit_q      <= 4'b0000;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         index_q      <= index_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         upd_ready_q  <= upd_ready_d;
         seg_q        <= seg_d;
         digit_q      <= digit_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign upd_ready  = upd_ready_q;
   assign seg        = seg_q;
   assign digit      = digit_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with ON_CYCLES=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_seg7_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic        upd_valid;
   logic        upd_ready;
   logic [15:0] upd_value;
   logic [3:0]  upd_dp;
   logic        lz_blank;
   logic [7:0]  seg;
   logic [3:0]  digit;
   logic        frame_tick;

   int n_cmp = 0;
   int n_err = 0;
   int e     = 0;

   seg7_scan_ctrl #(
      .ON_CYCLES    (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_value  (upd_value),
      .upd_dp     (upd_dp),
      .lz_blank   (lz_blank),
      .seg        (seg),
      .digit      (digit),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s @edge %0d: observed %h expected %h", tag, e, obs, exp);
      end
   endtask

   // Advance to the falling edge after rising edge number 'target' since reset release
   task automatic goto(input int target);
      while (e < target) begin
         @(negedge clk);
         e++;
      end
   endtask

   task automatic chk_disp(input string tag, input logic [7:0] exp_seg, input logic [3:0] exp_dig);
      chk({tag, ".seg"}, seg, exp_seg);
      chk({tag, ".digit"}, 8'(digit), 8'(exp_dig));
   endtask

   initial begin
      int p;
      rst_n     = 1'b0;
      upd_valid = 1'b0;
      upd_value = 16'h0000;
      upd_dp    = 4'b0000;
      lz_blank  = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk_disp("rst", 8'hFF, 4'b0000);
      chk("rst.ready", 8'(upd_ready), 8'h01);
      chk("rst.tick", 8'(frame_tick), 8'h00);

      rst_n = 1'b1;
      e     = 0;

      // First frame: two blank cycles then four ON cycles per digit, all showing "0"
      for (int k = 1; k <= 24; k++) begin
         goto(k);
         p = (k - 1) % 24;
         if ((p % 6) >= 2) chk_disp("frame0", 8'h03, 4'(1 << (p / 6)));
         else              chk_disp("frame0", 8'hFF, 4'b0000);
         chk("frame0.tick", 8'(frame_tick), (k == 24) ? 8'h01 : 8'h00);
      end

      // Single update 12AF with dp on digit 0
      goto(26);
      chk("upd.ready_before", 8'(upd_ready), 8'h01);
      upd_valid = 1'b1;
      upd_value = 16'h12AF;
      upd_dp    = 4'b0001;
      goto(27);
      upd_valid = 1'b0;
      chk("upd.ready_after", 8'(upd_ready), 8'h00);
      chk_disp("upd.old_d0", 8'h03, 4'b0001);
      goto(48);
      chk("upd.tick", 8'(frame_tick), 8'h01);
      chk("upd.ready_commit", 8'(upd_ready), 8'h00);
      chk_disp("upd.old_d3", 8'h03, 4'b1000);
      goto(49);
      chk("upd.ready_rise", 8'(upd_ready), 8'h01);
      chk("upd.tick_off", 8'(frame_tick), 8'h00);
      goto(51); chk_disp("upd.d0", 8'h70, 4'b0001);
      goto(57); chk_disp("upd.d1", 8'h11, 4'b0010);
      goto(63); chk_disp("upd.d2", 8'h25, 4'b0100);
      goto(69); chk_disp("upd.d3", 8'h9F, 4'b1000);
      goto(72); chk("upd.tick2", 8'(frame_tick), 8'h01);

      // Back-to-back: valid held, second value waits for the first to commit
      upd_valid = 1'b1;
      upd_value = 16'h1111;
      upd_dp    = 4'b0000;
      goto(73);
      chk("b2b.ready1", 8'(upd_ready), 8'h00);
      upd_value = 16'h2222;
      goto(96);
      chk("b2b.ready_hold", 8'(upd_ready), 8'h00);
      goto(97);
      chk("b2b.ready_rise", 8'(upd_ready), 8'h01);
      goto(98);
      chk("b2b.ready2", 8'(upd_ready), 8'h00);
      upd_valid = 1'b0;
      goto(99);  chk_disp("b2b.first_d0", 8'h9F, 4'b0001);
      goto(117); chk_disp("b2b.first_d3", 8'h9F, 4'b1000);
      goto(123); chk_disp("b2b.second_d0", 8'h25, 4'b0001);

      // Leading-zero blanking with 0050
      lz_blank  = 1'b1;
      upd_valid = 1'b1;
      upd_value = 16'h0050;
      upd_dp    = 4'b0000;
      goto(124);
      upd_valid = 1'b0;
      goto(147); chk_disp("lz50.d0", 8'h03, 4'b0001);
      upd_valid = 1'b1;
      upd_value = 16'h0000;
      upd_dp    = 4'b1111;
      goto(148);
      upd_valid = 1'b0;
      goto(153); chk_disp("lz50.d1", 8'h49, 4'b0010);
      goto(159); chk_disp("lz50.d2", 8'hFF, 4'b0100);
      goto(165); chk_disp("lz50.d3", 8'hFF, 4'b1000);
      goto(171); chk_disp("lz0.d0", 8'h02, 4'b0001);
      goto(177); chk_disp("lz0.d1", 8'hFF, 4'b0010);
      goto(183); chk_disp("lz0.d2", 8'hFF, 4'b0100);
      goto(189); chk_disp("lz0.d3", 8'hFF, 4'b1000);

      // Accept on the commit edge waits a full frame
      goto(191);
      lz_blank  = 1'b0;
      upd_valid = 1'b1;
      upd_value = 16'h8888;
      upd_dp    = 4'b0000;
      goto(192);
      upd_valid = 1'b0;
      chk("edge.tick", 8'(frame_tick), 8'h01);
      chk("edge.ready", 8'(upd_ready), 8'h00);
      goto(195); chk_disp("edge.not_yet_d0", 8'h02, 4'b0001);
      goto(201); chk_disp("edge.not_yet_d1", 8'h02, 4'b0010);
      goto(216); chk("edge.tick2", 8'(frame_tick), 8'h01);
      goto(219); chk_disp("edge.committed_d0", 8'h01, 4'b0001);

      // Reset mid-frame with an update pending
      upd_valid = 1'b1;
      upd_value = 16'h7777;
      goto(220);
      upd_valid = 1'b0;
      chk("mrst.pending", 8'(upd_ready), 8'h00);
      goto(221);
      chk_disp("mrst.lit", 8'h01, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk_disp("mrst.dark", 8'hFF, 4'b0000);
      chk("mrst.ready", 8'(upd_ready), 8'h01);
      chk("mrst.tick", 8'(frame_tick), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      e     = 0;
      goto(2);  chk_disp("mrst.blank", 8'hFF, 4'b0000);
      goto(3);  chk_disp("mrst.d0", 8'h03, 4'b0001);
      chk("mrst.ready_after", 8'(upd_ready), 8'h01);
      goto(24); chk("mrst.tick_after", 8'(frame_tick), 8'h01);
      goto(27); chk_disp("mrst.no_commit", 8'h03, 4'b0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
